mac_accum_stage: RTL and testbench
==================================

// Module: mac_accum_stage
// PURPOSE
//  Sequential back end of the MAC datapath, directly downstream of the 5:2 compressor tree.
//  - Takes the tree's redundant result (sum and carry vectors, already weight-aligned).
//  - Resolves the vector pair with a registered carry-propagate add.
//  - Accumulates the signed products of one dot product.
//  - Presents the total on a valid/ready output when the term flagged in_last has been absorbed.
// PARAMETERS
//  PROD_W  16  width of in_sum/in_carry and of the resolved two's-complement product
//  ACC_W   32  accumulator width; must be >= PROD_W
//  CNT_W   8   term-counter width
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       in_sum/in_carry/in_last hold a valid term
//  in_ready   out  1       stage can accept a term this cycle
//  in_sum     in   PROD_W  sum vector from the compressor tree
//  in_carry   in   PROD_W  carry vector from the tree, pre-shifted; product = in_sum + in_carry
//  in_last    in   1       this term is the final term of the dot product
//  in_clear   in   1       synchronous flush; lower priority than rst
//  out_valid  out  1       out_acc/out_count/out_ovf hold a finished result
//  out_ready  in   1       downstream accepts the result
//  out_acc    out  ACC_W   accumulated signed total
//  out_count  out  CNT_W   number of terms in the total
//  out_ovf    out  1       signed overflow occurred at least once during this total
// BEHAVIOUR
//  Reset / clear
//  - rst or in_clear: p_valid=0, acc=0, count=0, ovf=0, state=ACCUM.
//  - All outputs read 0 on the cycle after reset; in_ready=1.
//  - rst or in_clear mid-operation discards the buffered term and any partial or held result.
//  - A term offered in the same cycle as rst or in_clear is not accepted.
//  Stage 1 (resolve)
//  - p = (in_sum + in_carry) mod 2^PROD_W, signed.
//  - p is registered with in_last into p_reg/p_last; p_valid is set.
//  - Transfer happens on an edge where in_valid && in_ready.
//  Consume condition
//  - p_take = p_valid && (state==ACCUM || (state==HOLD && out_ready)).
//  - in_ready = !p_valid || p_take. This is a combinational path from out_ready; it is permitted.
//  - With p_valid=0, in_ready=1 regardless of state.
//  Stage 2 FSM (states ACCUM, HOLD)
//  - ACCUM, p_take:
//    - acc <= acc + sext(p_reg); count <= count+1; ovf |= signed_ovf.
//    - If p_last, go to HOLD.
//  - HOLD, out_ready && !p_take: go to ACCUM with acc=0, count=0, ovf=0.
//  - HOLD, out_ready && p_take (pop and new term on the same edge):
//    - acc <= sext(p_reg); count <= 1; ovf <= 0.
//    - Go to ACCUM, or stay in HOLD if p_last.
//  - HOLD, !out_ready: acc, count, ovf frozen; p_reg held; stage 1 back-pressured once p_valid=1.
//  Outputs
//  - out_valid = (state==HOLD).
//  - out_acc, out_count and out_ovf are the registered acc, count and ovf.
//  - They are stable while out_valid && !out_ready.
//  Arithmetic
//  - signed_ovf = (sign(acc)==sign(p) && sign(acc+p)!=sign(acc)).
//  - The accumulator wraps mod 2^ACC_W; no saturation.
//  - count saturates at 2^CNT_W-1; it does not wrap.
//  Latency
//  - A term accepted at edge k is absorbed at edge k+1 at the earliest.
//  - A last term accepted at edge k gives out_valid=1 after edge k+1.
//  - Sustained throughput is 1 term/cycle with out_ready=1, including back-to-back dot products.
//  Boundaries
//  - A single term with in_last=1 is a valid one-term dot product.
//  - in_sum+in_carry carry-out beyond PROD_W is discarded.
// TESTING
//  Each scenario below is checked against an independent behavioural model of the same equations.
//  - T1 basic dot product (PROD_W=16, ACC_W=32):
//    - Stimulus: terms (0x0003,0x0002), (0x0010,0x0000), (0xFFFF,0x0000, last).
//    - Required: out_acc=20 (5+16-1), out_count=3, out_ovf=0.
//  - T2 latency:
//    - Stimulus: single last term (0x0005,0x0001) accepted at edge k.
//    - Required: out_valid=1 after edge k+1, out_acc=6, out_count=1.
//  - T3 back-pressure:
//    - Stimulus: out_ready=0 for 5 cycles while the next dot product streams in.
//    - Required: in_ready drops after one buffered term, out_acc stays stable.
//    - Required: after out_ready=1, the second result is correct and no term is lost.
//  - T4 pop and new term on the same edge:
//    - Stimulus: in HOLD with out_ready=1 and p_valid=1.
//    - Required: the new total starts at sext(p_reg), count=1, ovf=0.
//  - T5 overflow (ACC_W=17):
//    - Stimulus: three terms 0x7FFF.
//    - Required: out_acc=0x17FFD (wrapped), out_ovf=1; the next dot product shows out_ovf=0.
//  - T6 flush:
//    - Stimulus: assert rst, and separately in_clear, mid-accumulation and during HOLD.
//    - Required: out_valid=0, out_acc=0, in_ready=1 on the next cycle; the subsequent dot product is correct.

Source files
------------

// File: rtl/mac_accum_stage.sv
// ---------------------------------------------------------------------------------------------
// mac_accum_stage
//
// Sequential back end of the MAC datapath. It sits directly after the 5:2 compressor tree and
// takes the tree's redundant result (a sum vector and an already weight-aligned carry vector).
//
//   Stage 1 (resolve)   : carry-propagate add of in_sum + in_carry, registered together with
//                         in_last into a one-entry term buffer.
//   Stage 2 (accumulate): two-state FSM (StAccum, StHold). It sums the signed products of one
//                         dot product. It holds the finished total on a valid/ready output
//                         until downstream takes it.
//
// Parameters
//   PROD_W  width of in_sum/in_carry and of the resolved two's-complement product
//   ACC_W   accumulator width (must be >= PROD_W)
//   CNT_W   term-counter width
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   a term is offered on in_sum/in_carry/in_last
//   in_ready   the stage accepts a term this cycle (combinational from out_ready)
//   in_sum     sum vector from the compressor tree
//   in_carry   pre-shifted carry vector, product = in_sum + in_carry
//   in_last    the offered term closes the dot product
//   in_clear   synchronous flush, lower priority than rst
//   out_valid  out_acc/out_count/out_ovf hold a finished result
//   out_ready  downstream accepts the result
//   out_acc    accumulated signed total (wraps mod 2^ACC_W)
//   out_count  number of terms in the total (saturating)
//   out_ovf    signed overflow happened at least once during this total
// ---------------------------------------------------------------------------------------------
module mac_accum_stage #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_sum,
    input  logic [PROD_W-1:0] in_carry,
    input  logic              in_last,
    input  logic              in_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [0:0] {
        StAccum,
        StHold
    } state_e;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_e            state_q, state_d;

    logic [PROD_W-1:0] p_q, p_d;
    logic              p_last_q, p_last_d;
    logic              p_valid_q, p_valid_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    // -----------------------------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------------------------
    logic [PROD_W-1:0] p_resolved;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic              ovf_now;
    logic [CNT_W-1:0]  cnt_inc;
    logic              p_take;
    logic              in_fire;

    // Carry-out beyond PROD_W is dropped: the product is defined mod 2^PROD_W.
    assign p_resolved = in_sum + in_carry;

    // Sign-extend the buffered product to accumulator width.
    assign p_ext      = ACC_W'($signed(p_q));

    assign acc_sum    = acc_q + p_ext;

    // Overflow only when both operands share a sign and the result's sign differs from it.
    assign ovf_now    = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) &&
                        (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    // Counter sticks at all-ones instead of wrapping.
    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // The buffered term leaves stage 1 when stage 2 is accumulating, or when the held result is
    // popped on this same edge.
    assign p_take     = p_valid_q && ((state_q == StAccum) || out_ready);

    // Buffer is free when empty or draining this edge; gives 1 term/cycle with out_ready=1.
    assign in_ready   = !p_valid_q || p_take;
    assign in_fire    = in_valid && in_ready;

    // -----------------------------------------------------------------------------------------
    // Stage 1: term buffer next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        p_d       = p_q;
        p_last_d  = p_last_q;
        p_valid_d = p_valid_q;

        if (in_fire) begin
            p_d       = p_resolved;
            p_last_d  = in_last;
            p_valid_d = 1'b1;
        end else if (p_take) begin
            p_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stage 2: accumulator FSM next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StAccum: begin
                if (p_take) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | ovf_now;
                    if (p_last_q) begin
                        state_d = StHold;
                    end
                end
            end

            StHold: begin
                // Without out_ready everything is frozen and stage 1 back-pressures.
                if (out_ready) begin
                    if (p_take) begin
                        // Pop and start the next total with the buffered term on the same edge.
                        acc_d   = p_ext;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = p_last_q ? StHold : StAccum;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = StAccum;
                    end
                end
            end

            default: begin
                state_d = StAccum;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Registers. rst and in_clear both flush; a term offered alongside them is dropped.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || in_clear) begin
            state_q   <= StAccum;
            p_q       <= '0;
            p_last_q  <= 1'b0;
            p_valid_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            p_last_q  <= p_last_d;
            p_valid_q <= p_valid_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign out_valid = (state_q == StHold);
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accum_stage.sv
// Bench for mac_accum_stage: a 32-bit accumulator instance (dut_a) and a 17-bit one (dut_b)
// for the wrap/overflow case. Results are predicted when the last term is driven, queued, and
// compared when the DUT hands the result over on out_valid && out_ready.
module tb_mac_accum_stage;

    typedef struct packed {
        logic [31:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] c;
        logic        last;
        logic [31:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_clear = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_sum = '0;
    logic [15:0] in_carry = '0;
    logic        in_last = 1'b0;
    logic        va = 1'b0;
    logic        vb = 1'b0;

    logic        rdy_a, rdy_b;
    logic        ov_a, ov_b;
    logic [31:0] acc_a;
    logic [16:0] acc_b;
    logic [7:0]  cnt_a, cnt_b;
    logic        ovf_a, ovf_b;

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;

    res_t        qa[$];
    res_t        qb[$];

    logic [31:0] m_acc = '0;
    logic [7:0]  m_cnt = '0;
    logic        m_ovf = 1'b0;

    vec_t        tbl [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_accum_stage #(.PROD_W(16), .ACC_W(32), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(rdy_a), .in_sum(in_sum),
        .in_carry(in_carry), .in_last(in_last), .in_clear(in_clear), .out_valid(ov_a),
        .out_ready(out_ready), .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a)
    );

    mac_accum_stage #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rdy_b), .in_sum(in_sum),
        .in_carry(in_carry), .in_last(in_last), .in_clear(in_clear), .out_valid(ov_b),
        .out_ready(out_ready), .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Behavioural model of the accumulation; pushes a prediction on the last term.
    task automatic model_term(input logic [15:0] s, input logic [15:0] c, input logic last);
        logic [15:0] p;
        logic [31:0] pe;
        logic [31:0] sum;
        p   = s + c;
        pe  = {{16{p[15]}}, p};
        sum = m_acc + pe;
        if ((m_acc[31] == pe[31]) && (sum[31] != m_acc[31])) m_ovf = 1'b1;
        m_acc = sum;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (last) begin
            qa.push_back('{acc: m_acc, cnt: m_cnt, ovf: m_ovf});
            m_acc = '0;
            m_cnt = '0;
            m_ovf = 1'b0;
        end
    endtask

    // Offer one term to dut_a (b=0) or dut_b (b=1); returns the cycle of the accepting edge.
    task automatic send(input bit b, input logic [15:0] s, input logic [15:0] c,
                        input logic last, output int acc_cyc);
        int n;
        in_sum   = s;
        in_carry = c;
        in_last  = last;
        if (b) vb = 1'b1;
        else va = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(b ? rdy_b : rdy_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accepted", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        va = 1'b0;
        vb = 1'b0;
    endtask

    task automatic tsend(input logic [15:0] s, input logic [15:0] c, input logic last);
        int dummy;
        model_term(s, c, last);
        send(1'b0, s, c, last, dummy);
    endtask

    task automatic usend(input logic [15:0] s, input logic [15:0] c, input logic last);
        int dummy;
        send(1'b0, s, c, last, dummy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(qa.size() + qb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Pulse rst or in_clear for one cycle, optionally offering a term in that cycle.
    task automatic flush(input bit use_rst, input bit offer);
        if (use_rst) rst = 1'b1;
        else in_clear = 1'b1;
        if (offer) begin
            in_sum   = 16'h0064;
            in_carry = 16'h0000;
            in_last  = 1'b1;
            va       = 1'b1;
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_clear = 1'b0;
        va       = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(ov_a), 32'd0);
        chk("flush_out_acc", acc_a, 32'd0);
        chk("flush_out_count", 32'(cnt_a), 32'd0);
        chk("flush_in_ready", 32'(rdy_a), 32'd1);
        @(negedge clk);
        chk("flush_term_dropped", 32'(ov_a), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare on each output handshake.
    always @(negedge clk) begin
        if (ov_a && out_ready) begin
            if (qa.size() == 0) begin
                total++;
                $display("FAIL unexpected_result_a: actual=%0h required=none", acc_a);
            end else begin
                res_t e;
                e = qa.pop_front();
                chk("res_acc_a", acc_a, e.acc);
                chk("res_cnt_a", 32'(cnt_a), 32'(e.cnt));
                chk("res_ovf_a", 32'(ovf_a), 32'(e.ovf));
            end
        end
        if (ov_b && out_ready) begin
            if (qb.size() == 0) begin
                total++;
                $display("FAIL unexpected_result_b: actual=%0h required=none", acc_b);
            end else begin
                res_t e;
                e = qb.pop_front();
                chk("res_acc_b", 32'(acc_b), e.acc);
                chk("res_cnt_b", 32'(cnt_b), 32'(e.cnt));
                chk("res_ovf_b", 32'(ovf_b), 32'(e.ovf));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, cx;

        tbl[0] = '{16'h0003, 16'h0002, 1'b0, 32'h0,        8'd0, 1'b0};
        tbl[1] = '{16'h0010, 16'h0000, 1'b0, 32'h0,        8'd0, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 32'd20,       8'd3, 1'b0};
        tbl[3] = '{16'h0005, 16'h0001, 1'b1, 32'd6,        8'd1, 1'b0};
        tbl[4] = '{16'hFFFF, 16'h0002, 1'b1, 32'd1,        8'd1, 1'b0};
        tbl[5] = '{16'h8000, 16'h0000, 1'b0, 32'h0,        8'd0, 1'b0};
        tbl[6] = '{16'h8000, 16'h0000, 1'b1, 32'hFFFF0000, 8'd2, 1'b0};
        tbl[7] = '{16'h1234, 16'h0F00, 1'b0, 32'h0,        8'd0, 1'b0};
        tbl[8] = '{16'h0000, 16'hFFFF, 1'b1, 32'h00002133, 8'd2, 1'b0};
        tbl[9] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'hFFFFFFFE, 8'd1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(ov_a), 32'd0);
        chk("reset_out_acc", acc_a, 32'd0);
        chk("reset_out_count", 32'(cnt_a), 32'd0);
        chk("reset_out_ovf", 32'(ovf_a), 32'd0);
        chk("reset_in_ready", 32'(rdy_a), 32'd1);
        chk("reset_b_out_valid", 32'(ov_b), 32'd0);
        @(posedge clk);
        #1;

        // Table vectors back to back with out_ready=1, including T1 and one-term totals
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].last) qa.push_back('{acc: tbl[i].acc, cnt: tbl[i].cnt, ovf: tbl[i].ovf});
            send(1'b0, tbl[i].s, tbl[i].c, tbl[i].last, cx);
            if (i == 0) c0 = cx;
            if (i == 9) c1 = cx;
        end
        chk("throughput_cycles", 32'(c1 - c0), 32'd9);
        drain();

        // T2 latency
        out_ready = 1'b0;
        tsend(16'h0005, 16'h0001, 1'b1);
        @(negedge clk);
        chk("latency_edge_k", 32'(ov_a), 32'd0);
        @(negedge clk);
        chk("latency_edge_k1", 32'(ov_a), 32'd1);
        chk("latency_acc", acc_a, 32'd6);
        chk("latency_count", 32'(cnt_a), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // T3 back-pressure, T4 pop with a new term on the same edge
        out_ready = 1'b0;
        tsend(16'h0001, 16'h0000, 1'b0);
        tsend(16'h0002, 16'h0000, 1'b1);
        fork
            begin
                tsend(16'h000A, 16'h0000, 1'b0);
                tsend(16'h0014, 16'h0000, 1'b0);
                tsend(16'h001E, 16'h0000, 1'b1);
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_out_valid", 32'(ov_a), 32'd1);
                    chk("bp_out_acc_stable", acc_a, 32'd3);
                    chk("bp_in_ready_low", 32'(rdy_a), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("pop_new_count", 32'(cnt_a), 32'd1);
                chk("pop_new_acc", acc_a, 32'd10);
                chk("pop_new_valid", 32'(ov_a), 32'd0);
            end
        join
        drain();

        // Count saturation: 260 terms of +1
        for (int i = 0; i < 260; i++) tsend(16'h0001, 16'h0000, (i == 259));
        drain();

        // T5 overflow on the 17-bit instance
        qb.push_back('{acc: 32'h00017FFD, cnt: 8'd3, ovf: 1'b1});
        send(1'b1, 16'h7FFF, 16'h0000, 1'b0, cx);
        send(1'b1, 16'h7FFF, 16'h0000, 1'b0, cx);
        send(1'b1, 16'h7FFF, 16'h0000, 1'b1, cx);
        qb.push_back('{acc: 32'h00000001, cnt: 8'd1, ovf: 1'b0});
        send(1'b1, 16'h0001, 16'h0000, 1'b1, cx);
        drain();

        // T6 flush: rst mid-accumulation
        usend(16'h0007, 16'h0000, 1'b0);
        usend(16'h0008, 16'h0000, 1'b0);
        flush(1'b1, 1'b1);
        tsend(16'h0002, 16'h0002, 1'b1);
        drain();

        // in_clear during HOLD, with a term offered in the clear cycle
        out_ready = 1'b0;
        usend(16'h0009, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        chk("hold_before_clear", 32'(ov_a), 32'd1);
        flush(1'b0, 1'b1);
        out_ready = 1'b1;
        tsend(16'h0003, 16'h0003, 1'b1);
        drain();

        // in_clear mid-accumulation
        usend(16'h0007, 16'h0000, 1'b0);
        flush(1'b0, 1'b0);

        // rst during HOLD
        out_ready = 1'b0;
        usend(16'h0009, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        flush(1'b1, 1'b1);
        out_ready = 1'b1;
        tsend(16'h0001, 16'h0001, 1'b0);
        tsend(16'h0002, 16'h0002, 1'b1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
